// File: rtl/riscv_pkg.sv
// Shared RV32I core types and reset defaults.
// if_id_t carries one decode slot. Both the IF/ID register and the skid entry use it.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer. It catches the in-flight fetch response while decode is stalled.
// When clear and load arrive together, clear wins. Load takes priority over drain.
module fetch_skid_buf
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   drain,
  input  logic   clear,
  input  if_id_t data_in,
  output logic   valid,
  output if_id_t data
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload is not reset. It is only consumed while valid is set, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (load && !clear) begin
      data <= data_in;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage and IF/ID pipeline register.
// Instruction memory has a 1-cycle read latency. Decode stalls are absorbed by a skid buffer. Redirects flush the stage.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  logic [31:0] pc_q;
  logic        inflight_q;
  logic [31:0] inflight_pc_q;
  logic        issue;

  if_id_t      if_id_q;
  if_id_t      if_id_d;
  if_id_t      fetched;
  if_id_t      skid_data;
  logic        skid_valid;
  logic        skid_load;
  logic        skid_drain;

  // A stall blocks issue, so the skid can only ever receive one response.
  assign issue     = !rst && (redirect_valid || !id_stall);
  assign imem_req  = issue;
  assign imem_addr = redirect_valid ? redirect_pc : pc_q;

  // NOTE: state registers use non-blocking assignments. Every flop then samples pre-edge values, with no dependence on process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q <= imem_addr + 32'd4;
      end
    end
  end

  // issue is low during reset, so this register holds without needing its own reset.
  always_ff @(posedge clk) begin
    if (issue) begin
      inflight_pc_q <= imem_addr;
    end
  end

  // NOTE: every always_comb output is given a default first. A path that leaves an output unassigned would infer a latch.
  always_comb begin
    fetched    = '{valid: 1'b1, inst: imem_rdata, pc: inflight_pc_q,
                   pc_plus4: inflight_pc_q + 32'd4};
    if_id_d    = if_id_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;

    if (redirect_valid) begin
      if_id_d.valid = 1'b0;
      if_id_d.inst  = NOP_INST;
    end else if (!id_stall) begin
      if (skid_valid) begin
        if_id_d    = skid_data;
        skid_drain = 1'b1;
      end else if (inflight_q) begin
        if_id_d = fetched;
      end else begin
        if_id_d.valid = 1'b0;
        if_id_d.inst  = NOP_INST;
      end
    end else if (inflight_q) begin
      skid_load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_q <= '{valid: 1'b0, inst: NOP_INST, pc: 32'd0, pc_plus4: 32'd4};
    end else begin
      if_id_q <= if_id_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (redirect_valid),
    .data_in (fetched),
    .valid   (skid_valid),
    .data    (skid_data)
  );

  assign id_valid    = if_id_q.valid;
  assign id_inst     = if_id_q.inst;
  assign id_pc       = if_id_q.pc;
  assign id_pc_plus4 = if_id_q.pc_plus4;

  a_skid_excludes_inflight : assert property (
    @(posedge clk) disable iff (rst) !(skid_valid && inflight_q)
  );

endmodule
